// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encodings,
// datapath mux-select encodings, ISA opcode/func values and the decoded
// instruction class record passed from the decoder to the FSM.
package mc_control_unit_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [1:0] SRC_B_REG = 2'd0;
   localparam logic [1:0] SRC_B_ONE = 2'd1;
   localparam logic [1:0] SRC_B_IMM = 2'd2;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_REG    = 2'd3;

   localparam logic [1:0] REG_DST_RT   = 2'd0;
   localparam logic [1:0] REG_DST_RD   = 2'd1;
   localparam logic [1:0] REG_DST_LINK = 2'd2;

   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   localparam logic [5:0] FN_ADD = 6'd0;
   localparam logic [5:0] FN_SUB = 6'd1;
   localparam logic [5:0] FN_AND = 6'd2;
   localparam logic [5:0] FN_ORR = 6'd3;
   localparam logic [5:0] FN_NOT = 6'd4;
   localparam logic [5:0] FN_TCP = 6'd5;
   localparam logic [5:0] FN_SHL = 6'd6;
   localparam logic [5:0] FN_SHR = 6'd7;
   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   // jump covers JMP/JAL/JPR/JRL; jump_reg picks register A as the target,
   // link marks the variants that also write the return address.
   typedef struct packed {
      logic rtype;
      logic imm;
      logic branch;
      logic load;
      logic store;
      logic jump;
      logic jump_reg;
      logic link;
      logic wwd;
      logic hlt;
      logic invalid;
   } inst_class_t;

endpackage

// File: rtl/mc_control_unit_decode.sv
// Combinational instruction classifier: turns the IR opcode/func fields
// into the class flags the control FSM steers on.
module mc_decode
   import mc_control_unit_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [5:0]  func,
   output inst_class_t cls
);

   // Classify the instruction; anything not listed is flagged invalid.
   always_comb begin
      cls = '0;
      case (opcode)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls.branch = 1'b1;
         OP_ADI, OP_ORI, OP_LHI:         cls.imm    = 1'b1;
         OP_LWD:                         cls.load   = 1'b1;
         OP_SWD:                         cls.store  = 1'b1;
         OP_JMP:                         cls.jump   = 1'b1;
         OP_JAL: begin
            cls.jump = 1'b1;
            cls.link = 1'b1;
         end
         OP_RTYPE: begin
            case (func)
               FN_ADD, FN_SUB, FN_AND, FN_ORR,
               FN_NOT, FN_TCP, FN_SHL, FN_SHR: cls.rtype = 1'b1;
               FN_JPR: begin
                  cls.jump     = 1'b1;
                  cls.jump_reg = 1'b1;
               end
               FN_JRL: begin
                  cls.jump     = 1'b1;
                  cls.jump_reg = 1'b1;
                  cls.link     = 1'b1;
               end
               FN_WWD:  cls.wwd     = 1'b1;
               FN_HLT:  cls.hlt     = 1'b1;
               default: cls.invalid = 1'b1;
            endcase
         end
         default: cls.invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle CPU control unit: IF/ID/EX/MEM/WB/HALT sequencer driving the
// datapath strobes and mux selects, plus a retired-instruction counter.
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int WORD_SIZE = 16
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [3:0]           opcode,
   input  logic [5:0]           func,
   input  logic                 alu_zero,
   input  logic                 mem_ack,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 reg_write,
   output logic                 mem_to_reg,
   output logic                 wwd_en,
   output logic                 is_halted,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           pc_source,
   output logic [1:0]           reg_dst,
   output logic [WORD_SIZE-1:0] num_inst
);

   localparam logic [WORD_SIZE-1:0] WORD_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   state_t                 state;
   state_t                 next_state;
   inst_class_t            cls;
   logic                   retire;
   logic [WORD_SIZE-1:0]   count;

   mc_decode u_decode (
      .opcode (opcode),
      .func   (func),
      .cls    (cls)
   );

   // An instruction retires when the FSM leaves a working state for IF or HALT.
   assign retire = (state != S_IF) && (state != S_HALT) &&
                   ((next_state == S_IF) || (next_state == S_HALT));

   // The count reads as zero while reset is held so every output is quiet.
   assign num_inst = reset_n ? count : '0;

   // State register and retirement counter; reset restarts at IF without retiring.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IF;
         count <= '0;
      end else begin
         state <= next_state;
         if (retire) begin
            count <= count + WORD_ONE;
         end
      end
   end

   // Next-state and control outputs for the current state; all quiet during reset.
   always_comb begin
      next_state    = state;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      wwd_en        = 1'b0;
      is_halted     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_REG;
      pc_source     = PC_SRC_ALU;
      reg_dst       = REG_DST_RT;

      case (state)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = SRC_B_ONE;
            if (mem_ack) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               next_state = S_ID;
            end
         end
         S_ID: begin
            if (cls.hlt) begin
               next_state = S_HALT;
            end else if (cls.invalid) begin
               next_state = S_IF;
            end else if (cls.wwd) begin
               wwd_en     = 1'b1;
               next_state = S_IF;
            end else if (cls.jump) begin
               pc_write  = 1'b1;
               pc_source = cls.jump_reg ? PC_SRC_REG : PC_SRC_JUMP;
               if (cls.link) begin
                  reg_write = 1'b1;
                  reg_dst   = REG_DST_LINK;
               end
               next_state = S_IF;
            end else begin
               next_state = S_EX;
            end
         end
         S_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = (cls.imm || cls.load || cls.store) ? SRC_B_IMM : SRC_B_REG;
            if (cls.branch) begin
               pc_write_cond = 1'b1;
               pc_source     = PC_SRC_BRANCH;
               next_state    = S_IF;
            end else if (cls.load || cls.store) begin
               next_state = S_MEM;
            end else begin
               next_state = S_WB;
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = cls.load;
            mem_write = cls.store;
            if (mem_ack) begin
               next_state = cls.load ? S_WB : S_IF;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = cls.rtype ? REG_DST_RD : REG_DST_RT;
            mem_to_reg = cls.load;
            next_state = S_IF;
         end
         S_HALT: begin
            is_halted = 1'b1;
         end
         default: begin
            next_state = S_IF;
         end
      endcase

      if (!reset_n) begin
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         i_or_d        = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         reg_write     = 1'b0;
         mem_to_reg    = 1'b0;
         wwd_en        = 1'b0;
         is_halted     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = SRC_B_REG;
         pc_source     = PC_SRC_ALU;
         reg_dst       = REG_DST_RT;
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: every driven cycle queues its
// hand-derived expected control vector; a negedge monitor pops and compares.
// A second instance with a 4-bit counter shares the stimulus so the
// all-ones-to-zero wrap of the retirement counter is reached in few cycles.
module tb_mc_control_unit;

   localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_ADI = 4'd4, OP_LWD = 4'd7,
                          OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_BAD = 4'd12,
                          OP_R   = 4'd15;
   localparam logic [5:0] FN_ADD = 6'd0, FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28,
                          FN_HLT = 6'd29, FN_BAD = 6'd10;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       reg_write;
      logic       mem_to_reg;
      logic       wwd_en;
      logic       is_halted;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] reg_dst;
   } ctrl_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [15:0] num;
      logic [3:0]  num_narrow;
   } obs_t;

   logic        clk;
   logic        reset_n;
   logic [3:0]  opcode;
   logic [5:0]  func;
   logic        alu_zero;
   logic        mem_ack;

   logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
   logic        reg_write, mem_to_reg, wwd_en, is_halted, alu_src_a;
   logic [1:0]  alu_src_b, pc_source, reg_dst;
   logic [15:0] num_inst;

   logic        n_mem_read, n_mem_write, n_i_or_d, n_ir_write, n_pc_write, n_pc_write_cond;
   logic        n_reg_write, n_mem_to_reg, n_wwd_en, n_is_halted, n_alu_src_a;
   logic [1:0]  n_alu_src_b, n_pc_source, n_reg_dst;
   logic [3:0]  n_num_inst;

   ctrl_t       act_ctrl;
   ctrl_t       n_ctrl;
   obs_t        act;
   obs_t        head;
   string       head_name;

   obs_t        exp_q[$];
   string       name_q[$];
   int          checks;
   int          errors;
   int          retired;

   mc_control_unit #(.WORD_SIZE(16)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
      .alu_zero(alu_zero), .mem_ack(mem_ack),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .wwd_en(wwd_en),
      .is_halted(is_halted), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .reg_dst(reg_dst), .num_inst(num_inst)
   );

   mc_control_unit #(.WORD_SIZE(4)) dut_narrow (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
      .alu_zero(alu_zero), .mem_ack(mem_ack),
      .mem_read(n_mem_read), .mem_write(n_mem_write), .i_or_d(n_i_or_d),
      .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond),
      .reg_write(n_reg_write), .mem_to_reg(n_mem_to_reg), .wwd_en(n_wwd_en),
      .is_halted(n_is_halted), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
      .pc_source(n_pc_source), .reg_dst(n_reg_dst), .num_inst(n_num_inst)
   );

   assign act_ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                      reg_write, mem_to_reg, wwd_en, is_halted, alu_src_a,
                      alu_src_b, pc_source, reg_dst};
   assign n_ctrl   = {n_mem_read, n_mem_write, n_i_or_d, n_ir_write, n_pc_write,
                      n_pc_write_cond, n_reg_write, n_mem_to_reg, n_wwd_en,
                      n_is_halted, n_alu_src_a, n_alu_src_b, n_pc_source, n_reg_dst};
   assign act      = {act_ctrl, num_inst, n_num_inst};

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected control vectors, one constructor per observable pattern.
   function automatic ctrl_t c_zero();
      ctrl_t c;
      c = '0;
      return c;
   endfunction

   function automatic ctrl_t c_fetch(input logic ack);
      ctrl_t c;
      c = '0;
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'd1;
      c.ir_write  = ack;
      c.pc_write  = ack;
      return c;
   endfunction

   function automatic ctrl_t c_jump(input logic [1:0] pcs, input logic link);
      ctrl_t c;
      c = '0;
      c.pc_write  = 1'b1;
      c.pc_source = pcs;
      c.reg_write = link;
      c.reg_dst   = link ? 2'd2 : 2'd0;
      return c;
   endfunction

   function automatic ctrl_t c_wwd();
      ctrl_t c;
      c = '0;
      c.wwd_en = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t c_ex(input logic [1:0] srcb, input logic br);
      ctrl_t c;
      c = '0;
      c.alu_src_a     = 1'b1;
      c.alu_src_b     = srcb;
      c.pc_write_cond = br;
      c.pc_source     = br ? 2'd1 : 2'd0;
      return c;
   endfunction

   function automatic ctrl_t c_mem(input logic wr);
      ctrl_t c;
      c = '0;
      c.i_or_d    = 1'b1;
      c.mem_read  = ~wr;
      c.mem_write = wr;
      return c;
   endfunction

   function automatic ctrl_t c_wb(input logic [1:0] dst, input logic m2r);
      ctrl_t c;
      c = '0;
      c.reg_write  = 1'b1;
      c.reg_dst    = dst;
      c.mem_to_reg = m2r;
      return c;
   endfunction

   function automatic ctrl_t c_halt();
      ctrl_t c;
      c = '0;
      c.is_halted = 1'b1;
      return c;
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue its expectation.
   task automatic applyStimulus(input logic rstn, input logic [3:0] op, input logic [5:0] fn,
                                input logic zero, input logic ack, input ctrl_t exp_ctrl,
                                input string name);
      obs_t e;
      @(posedge clk);
      #1;
      reset_n  = rstn;
      opcode   = op;
      func     = fn;
      alu_zero = zero;
      mem_ack  = ack;
      e.ctrl       = exp_ctrl;
      e.num        = rstn ? retired[15:0] : 16'd0;
      e.num_narrow = rstn ? retired[3:0]  : 4'd0;
      exp_q.push_back(e);
      name_q.push_back(name);
      if (!rstn) retired = 0;
   endtask

   task automatic fetch(input logic [3:0] op, input logic [5:0] fn, input int waits);
      for (int i = 0; i < waits; i++) applyStimulus(1'b1, op, fn, 1'b0, 1'b0, c_fetch(1'b0), "if_wait");
      applyStimulus(1'b1, op, fn, 1'b0, 1'b1, c_fetch(1'b1), "if_ack");
   endtask

   // Pop the oldest expectation and compare both instances against it.
   task automatic checkOutput();
      head      = exp_q.pop_front();
      head_name = name_q.pop_front();
      checks++;
      if (act !== head || n_ctrl !== head.ctrl) begin
         errors++;
         $display("[TB] FAIL %s: got ctrl=%h num=%h narrow=%h narrow_ctrl=%h, want ctrl=%h num=%h narrow=%h",
                  head_name, act.ctrl, act.num, act.num_narrow, n_ctrl,
                  head.ctrl, head.num, head.num_narrow);
      end
   endtask

   // Monitor: compare whatever the DUT presents mid-cycle against the queue head.
   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput();
   end

   // Directed instruction sequences.
   initial begin
      checks   = 0;
      errors   = 0;
      retired  = 0;
      reset_n  = 1'b0;
      opcode   = OP_R;
      func     = FN_ADD;
      alu_zero = 1'b0;
      mem_ack  = 1'b0;

      applyStimulus(1'b0, OP_R, FN_ADD, 1'b0, 1'b1, c_zero(), "reset_quiet");
      applyStimulus(1'b0, OP_R, FN_ADD, 1'b0, 1'b0, c_zero(), "reset_quiet2");

      // ADD, ack on first fetch cycle; stray acks in ID/EX must be ignored.
      fetch(OP_R, FN_ADD, 0);
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b1, c_zero(), "add_id");
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b1, c_ex(2'd0, 1'b0), "add_ex");
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b0, c_wb(2'd1, 1'b0), "add_wb");
      retired++;

      // LWD with the memory ack three cycles late.
      fetch(OP_LWD, 6'd0, 0);
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_zero(), "lwd_id");
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_ex(2'd2, 1'b0), "lwd_ex");
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_mem(1'b0), "lwd_mem_wait");
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b1, c_mem(1'b0), "lwd_mem_ack");
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_wb(2'd0, 1'b1), "lwd_wb");
      retired++;

      // SWD with a slow fetch, then straight back to IF after the write.
      fetch(OP_SWD, 6'd0, 2);
      applyStimulus(1'b1, OP_SWD, 6'd0, 1'b0, 1'b0, c_zero(), "swd_id");
      applyStimulus(1'b1, OP_SWD, 6'd0, 1'b0, 1'b0, c_ex(2'd2, 1'b0), "swd_ex");
      applyStimulus(1'b1, OP_SWD, 6'd0, 1'b0, 1'b0, c_mem(1'b1), "swd_mem_wait");
      applyStimulus(1'b1, OP_SWD, 6'd0, 1'b0, 1'b1, c_mem(1'b1), "swd_mem_ack");
      retired++;

      // Branches retire out of EX regardless of alu_zero.
      fetch(OP_BEQ, 6'd0, 0);
      applyStimulus(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, c_zero(), "beq_id");
      applyStimulus(1'b1, OP_BEQ, 6'd0, 1'b0, 1'b0, c_ex(2'd0, 1'b1), "beq_ex");
      retired++;
      fetch(OP_BNE, 6'd0, 0);
      applyStimulus(1'b1, OP_BNE, 6'd0, 1'b1, 1'b0, c_zero(), "bne_id");
      applyStimulus(1'b1, OP_BNE, 6'd0, 1'b1, 1'b0, c_ex(2'd0, 1'b1), "bne_ex");
      retired++;

      // Immediate ALU op writes rt.
      fetch(OP_ADI, 6'd0, 0);
      applyStimulus(1'b1, OP_ADI, 6'd0, 1'b0, 1'b0, c_zero(), "adi_id");
      applyStimulus(1'b1, OP_ADI, 6'd0, 1'b0, 1'b0, c_ex(2'd2, 1'b0), "adi_ex");
      applyStimulus(1'b1, OP_ADI, 6'd0, 1'b0, 1'b0, c_wb(2'd0, 1'b0), "adi_wb");
      retired++;

      // Jumps resolve in ID.
      fetch(OP_JAL, 6'd0, 0);
      applyStimulus(1'b1, OP_JAL, 6'd0, 1'b0, 1'b0, c_jump(2'd2, 1'b1), "jal_id");
      retired++;
      fetch(OP_JMP, 6'd0, 0);
      applyStimulus(1'b1, OP_JMP, 6'd0, 1'b0, 1'b0, c_jump(2'd2, 1'b0), "jmp_id");
      retired++;
      fetch(OP_R, FN_JPR, 0);
      applyStimulus(1'b1, OP_R, FN_JPR, 1'b0, 1'b0, c_jump(2'd3, 1'b0), "jpr_id");
      retired++;
      fetch(OP_R, FN_JRL, 0);
      applyStimulus(1'b1, OP_R, FN_JRL, 1'b0, 1'b0, c_jump(2'd3, 1'b1), "jrl_id");
      retired++;

      // WWD pulses once; the following fetch cycle shows no wwd_en.
      fetch(OP_R, FN_WWD, 0);
      applyStimulus(1'b1, OP_R, FN_WWD, 1'b0, 1'b0, c_wwd(), "wwd_id");
      retired++;

      // Unrecognised opcode and func retire as NOPs; then enough NOPs to wrap the 4-bit counter.
      fetch(OP_BAD, 6'd0, 0);
      applyStimulus(1'b1, OP_BAD, 6'd0, 1'b0, 1'b0, c_zero(), "badop_id");
      retired++;
      for (int i = 0; i < 21; i++) begin
         fetch(OP_R, FN_BAD, 0);
         applyStimulus(1'b1, OP_R, FN_BAD, 1'b0, 1'b0, c_zero(), "nop_id");
         retired++;
      end

      // Reset while LWD waits in MEM: abandoned, count cleared, fetch restarts.
      fetch(OP_LWD, 6'd0, 0);
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_zero(), "lwd2_id");
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_ex(2'd2, 1'b0), "lwd2_ex");
      applyStimulus(1'b1, OP_LWD, 6'd0, 1'b0, 1'b0, c_mem(1'b0), "lwd2_mem_wait");
      applyStimulus(1'b0, OP_LWD, 6'd0, 1'b0, 1'b1, c_zero(), "reset_in_mem");
      fetch(OP_R, FN_ADD, 1);
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b0, c_zero(), "add2_id");
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b0, c_ex(2'd0, 1'b0), "add2_ex");
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b0, c_wb(2'd1, 1'b0), "add2_wb");
      retired++;

      // HLT retires into a sticky HALT that ignores every input until reset.
      fetch(OP_R, FN_HLT, 0);
      applyStimulus(1'b1, OP_R, FN_HLT, 1'b0, 1'b0, c_zero(), "hlt_id");
      retired++;
      for (int i = 0; i < 20; i++)
         applyStimulus(1'b1, 4'(i), 6'(i), i[0], ~i[0], c_halt(), "halt_hold");
      applyStimulus(1'b0, OP_R, FN_ADD, 1'b0, 1'b0, c_zero(), "reset_from_halt");
      applyStimulus(1'b1, OP_R, FN_ADD, 1'b0, 1'b0, c_fetch(1'b0), "if_after_halt");

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
